// File: rtl/trigger_control_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trigger_control_gen : hysteresis level/edge trigger with holdoff and modes  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trigger_control_gen #(
   parameter int DATA_W       = 8,
   parameter int HOLDOFF_W    = 16,
   parameter int AUTO_TIMEOUT = 200000,
   parameter int AUTO_W       = 18
) (
   input  logic                 clk_20M,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    data,
   input  logic [DATA_W-1:0]    trigger_level,
   input  logic [DATA_W-1:0]    hysteresis,
   input  logic [1:0]           edge_sel,
   input  logic [1:0]           trig_mode,
   input  logic                 arm,
   input  logic [HOLDOFF_W-1:0] holdoff,
   output logic                 trigger_activation,
   output logic                 auto_fired,
   output logic                 armed,
   output logic                 level_above
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ARMED   = 2'd1;
   localparam logic [1:0] S_HOLDOFF = 2'd2;

   localparam logic [AUTO_W-1:0] C_AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);

   logic [DATA_W:0]     w_sum;
   logic [DATA_W-1:0]   w_upper;
   logic [DATA_W-1:0]   w_lower;
   logic                r_above;
   logic                r_above_d;
   logic                w_rise;
   logic                w_fall;
   logic                w_qual;
   logic                w_single;
   logic                w_auto;
   logic                w_timeout;

   logic [1:0]           r_state;
   logic [1:0]           w_next_state;
   logic [HOLDOFF_W-1:0] r_hold_cnt;
   logic [HOLDOFF_W-1:0] w_hold_next;
   logic [AUTO_W-1:0]    r_auto_cnt;
   logic [AUTO_W-1:0]    w_auto_next;
   logic                 w_fire;
   logic                 w_auto_fire;
   logic                 r_trig;
   logic                 r_auto_fired;

   // Thresholds clamp to the sample range instead of wrapping
   assign w_sum   = {1'b0, trigger_level} + {1'b0, hysteresis};
   assign w_upper = w_sum[DATA_W] ? {DATA_W{1'b1}} : w_sum[DATA_W-1:0];
   assign w_lower = (trigger_level > hysteresis) ? (trigger_level - hysteresis) : '0;

   always_ff @(posedge clk_20M) begin
      if (rst) begin
         r_above   <= 1'b0;
         r_above_d <= 1'b0;
      end else begin
         r_above_d <= r_above;
         if (!r_above && (data > w_upper))
            r_above <= 1'b1;
         else if (r_above && (data <= w_lower))
            r_above <= 1'b0;
      end
   end

   assign w_rise = r_above & ~r_above_d;
   assign w_fall = ~r_above & r_above_d;

   always_comb begin
      w_qual = w_rise;
      case (edge_sel)
         2'b01:   w_qual = w_fall;
         2'b10:   w_qual = w_rise | w_fall;
         default: w_qual = w_rise;
      endcase
   end

   assign w_single  = (trig_mode == 2'b10);
   assign w_auto    = (trig_mode == 2'b00);
   assign w_timeout = w_auto && (r_auto_cnt == C_AUTO_LAST);

   always_ff @(posedge clk_20M) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_hold_cnt   <= '0;
         r_auto_cnt   <= '0;
         r_trig       <= 1'b0;
         r_auto_fired <= 1'b0;
      end else begin
         r_state      <= w_next_state;
         r_hold_cnt   <= w_hold_next;
         r_auto_cnt   <= w_auto_next;
         r_trig       <= w_fire;
         r_auto_fired <= w_auto_fire;
      end
   end

   // Auto count defaults to zero so every entry to ARMED starts a fresh timeout
   always_comb begin
      w_next_state = r_state;
      w_hold_next  = r_hold_cnt;
      w_auto_next  = '0;
      w_fire       = 1'b0;
      w_auto_fire  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_single || arm)
               w_next_state = S_ARMED;
         end
         S_ARMED: begin
            if (w_qual || w_timeout) begin
               w_fire      = 1'b1;
               w_auto_fire = !w_qual;
               w_hold_next = holdoff;
               if (holdoff == '0)
                  w_next_state = w_single ? S_IDLE : S_ARMED;
               else
                  w_next_state = S_HOLDOFF;
            end else if (w_auto) begin
               w_auto_next = r_auto_cnt + 1'b1;
            end
         end
         S_HOLDOFF: begin
            if (r_hold_cnt <= 1) begin
               w_hold_next  = '0;
               w_next_state = w_single ? S_IDLE : S_ARMED;
            end else begin
               w_hold_next = r_hold_cnt - 1'b1;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_comb begin
      armed              = (r_state == S_ARMED);
      trigger_activation = r_trig;
      auto_fired         = r_auto_fired;
      level_above        = r_above;
   end

endmodule
`default_nettype wire

// File: tb/tb_trigger_control_gen.sv
`default_nettype none
// Directed bench for trigger_control_gen: vector table plus multi-cycle sequences.
module tb_trigger_control_gen;

   logic        clk_20M = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  data = '0;
   logic [7:0]  trigger_level = 8'd128;
   logic [7:0]  hysteresis = '0;
   logic [1:0]  edge_sel = 2'b00;
   logic [1:0]  trig_mode = 2'b01;
   logic        arm = 1'b0;
   logic [15:0] holdoff = '0;
   logic        trigger_activation;
   logic        auto_fired;
   logic        armed;
   logic        level_above;

   int n_checks = 0;
   int n_err    = 0;

   typedef struct {
      logic        rst;
      logic [7:0]  d;
      logic [7:0]  lvl;
      logic [7:0]  hyst;
      logic [1:0]  esel;
      logic [1:0]  mode;
      logic        arm;
      logic [15:0] hold;
      logic        e_trig;
      logic        e_auto;
      logic        e_armed;
      logic        e_above;
   } vec_t;

   vec_t tbl[$];

   trigger_control_gen #(
      .DATA_W       (8),
      .HOLDOFF_W    (16),
      .AUTO_TIMEOUT (16),
      .AUTO_W       (18)
   ) dut (
      .clk_20M            (clk_20M),
      .rst                (rst),
      .data               (data),
      .trigger_level      (trigger_level),
      .hysteresis         (hysteresis),
      .edge_sel           (edge_sel),
      .trig_mode          (trig_mode),
      .arm                (arm),
      .holdoff            (holdoff),
      .trigger_activation (trigger_activation),
      .auto_fired         (auto_fired),
      .armed              (armed),
      .level_above        (level_above)
   );

   always #25 clk_20M = ~clk_20M;

   function automatic vec_t mk(input logic r, input logic [7:0] d, input logic [7:0] l,
                               input logic [7:0] h, input logic [1:0] es, input logic [1:0] md,
                               input logic ar, input logic [15:0] ho, input logic et,
                               input logic ea, input logic earm, input logic eab);
      vec_t v;
      v.rst = r; v.d = d; v.lvl = l; v.hyst = h; v.esel = es; v.mode = md;
      v.arm = ar; v.hold = ho; v.e_trig = et; v.e_auto = ea; v.e_armed = earm; v.e_above = eab;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk_20M);
      #1;
   endtask

   task automatic check(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic et, input logic ea,
                          input logic earm, input logic eab);
      check({tag, " trig"},  trigger_activation, et);
      check({tag, " auto"},  auto_fired,         ea);
      check({tag, " armed"}, armed,              earm);
      check({tag, " above"}, level_above,        eab);
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      tick();
      chk_out({tag, " reset"}, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   initial begin
      // Test 1: normal rising ramp, level 128, no hysteresis
      tbl.push_back(mk(1, 100, 128, 0, 0, 1, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 100, 128, 0, 0, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 110, 128, 0, 0, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 120, 128, 0, 0, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 130, 128, 0, 0, 1, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 140, 128, 0, 0, 1, 0, 0,  1, 0, 1, 1));
      tbl.push_back(mk(0, 150, 128, 0, 0, 1, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 160, 128, 0, 0, 1, 0, 0,  0, 0, 1, 1));
      // Test 2: hysteresis 8 -> upper 136, lower 120
      tbl.push_back(mk(0, 100, 128, 8, 0, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 100, 128, 8, 0, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 136, 128, 8, 0, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 121, 128, 8, 0, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 135, 128, 8, 0, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 125, 128, 8, 0, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 137, 128, 8, 0, 1, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 137, 128, 8, 0, 1, 0, 0,  1, 0, 1, 1));
      tbl.push_back(mk(0, 137, 128, 8, 1, 1, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 121, 128, 8, 1, 1, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 121, 128, 8, 1, 1, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 120, 128, 8, 1, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 120, 128, 8, 1, 1, 0, 0,  1, 0, 1, 0));
      tbl.push_back(mk(0, 120, 128, 8, 1, 1, 0, 0,  0, 0, 1, 0));
      // Saturation: upper clamps to 255, lower clamps to 0
      tbl.push_back(mk(0, 255, 250, 10, 0, 1, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 255, 250, 10, 0, 1, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(0, 16,  5,  10, 0, 1, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 16,  5,  10, 0, 1, 0, 0,  1, 0, 1, 1));
      tbl.push_back(mk(0, 1,   5,  10, 1, 1, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 1,   5,  10, 1, 1, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 0,   5,  10, 1, 1, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 0,   5,  10, 1, 1, 0, 0,  1, 0, 1, 0));
      tbl.push_back(mk(0, 0,   5,  10, 1, 1, 0, 0,  0, 0, 1, 0));
      // Test 5: single shot; edge at the IDLE->ARMED cycle is discarded
      tbl.push_back(mk(1, 0,   128, 0, 0, 2, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 0,   128, 0, 0, 2, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 0,  0, 0, 0, 1));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 1, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 0,   128, 0, 0, 2, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 0,   128, 0, 0, 2, 0, 0,  0, 0, 1, 0));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 0,  0, 0, 1, 1));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 0,  1, 0, 0, 1));
      tbl.push_back(mk(0, 0,   128, 0, 0, 2, 0, 0,  0, 0, 0, 0));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 0,  0, 0, 0, 1));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 0,  0, 0, 0, 1));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 0,  0, 0, 0, 1));
      // Single shot with holdoff 3; arm during HOLDOFF must be ignored
      tbl.push_back(mk(0, 0,   128, 0, 0, 2, 1, 3,  0, 0, 1, 0));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 3,  0, 0, 1, 1));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 3,  1, 0, 0, 1));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 1, 3,  0, 0, 0, 1));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 3,  0, 0, 0, 1));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 3,  0, 0, 0, 1));
      tbl.push_back(mk(0, 255, 128, 0, 0, 2, 0, 3,  0, 0, 0, 1));

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; data = tbl[i].d; trigger_level = tbl[i].lvl;
         hysteresis = tbl[i].hyst; edge_sel = tbl[i].esel; trig_mode = tbl[i].mode;
         arm = tbl[i].arm; holdoff = tbl[i].hold;
         tick();
         chk_out($sformatf("vec%0d", i), tbl[i].e_trig, tbl[i].e_auto,
                 tbl[i].e_armed, tbl[i].e_above);
      end
      arm = 1'b0;

      // Test 3: both edges, holdoff 5, square wave period 4 -> pulse every 6 cycles
      data = 0; trigger_level = 128; hysteresis = 0; edge_sel = 2'b10;
      trig_mode = 2'b01; holdoff = 5;
      do_reset("t3");
      tick();
      chk_out("t3 release", 1'b0, 1'b0, 1'b1, 1'b0);
      for (int j = 0; j < 20; j++) begin
         data = ((j % 4) < 2) ? 8'd255 : 8'd0;
         tick();
         chk_out($sformatf("t3 j%0d", j), (j % 6) == 1, 1'b0,
                 (j == 0) || ((j % 6) == 0), (j % 4) < 2);
      end

      // Test 4: auto mode, timeout 16; edge coincident with a timeout wins
      data = 0; edge_sel = 2'b00; trig_mode = 2'b00; holdoff = 0;
      do_reset("t4");
      for (int k = 1; k <= 66; k++) begin
         data = (k >= 64) ? 8'd255 : 8'd0;
         tick();
         chk_out($sformatf("t4 k%0d", k), (k > 1) && ((k % 16) == 1),
                 (k > 1) && ((k % 16) == 1) && (k != 65), 1'b1, k >= 64);
      end

      // Test 6: reset in the middle of a long holdoff
      data = 0; trig_mode = 2'b01; holdoff = 1000;
      do_reset("t6");
      tick();
      chk_out("t6 release", 1'b0, 1'b0, 1'b1, 1'b0);
      data = 255;
      tick();
      chk_out("t6 rise", 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk_out("t6 fire", 1'b1, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_out($sformatf("t6 hold%0d", k), 1'b0, 1'b0, 1'b0, 1'b1);
      end
      rst = 1'b1;
      tick();
      chk_out("t6 rst mid", 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      chk_out("t6 after rst", 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk_out("t6 refire", 1'b1, 1'b0, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
